vga_scanout: RTL
================

// Module: vga_scanout
// PURPOSE
//  Reads the 3-bit-per-pixel framebuffer written by the text/box drawing unit and produces 640x480@60Hz VGA
//  timing. Framebuffer address is {y[8:0], x[7:0]}. Each logical pixel is scaled 2^SCALE_SHIFT times in x and y.
//  Sits between the framebuffer read port and the board DAC/sync pins. Exports vblank/frameStart so the draw side
//  can schedule updates.
// PARAMETERS
//  SCALE_SHIFT  2  log2 of the pixel replication factor. Logical x = hcount>>SCALE_SHIFT, logical y = vcount>>SCALE_SHIFT.
//  MEM_LATENCY  1  clk50 cycles from readAddress/readEn valid to readData valid. Legal range 1..4.
// PORTS
//  clk50        in   1   50 MHz system clock
//  reset        in   1   asynchronous, active-high reset
//  readEn       out  1   framebuffer read strobe; high only while the addressed pixel is visible
//  readAddress  out  17  {ly[8:0], lx[7:0]}; ly, lx are logical coordinates
//  readData     in   3   pixel colour returned MEM_LATENCY cycles after the request: {R,G,B}
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  red          out  1   colour bit 2, forced 0 outside the visible area
//  green        out  1   colour bit 1, forced 0 outside the visible area
//  blue         out  1   colour bit 0, forced 0 outside the visible area
//  vblank       out  1   high while vcount >= 480 (stage-0 timing, not delayed)
//  frameStart   out  1   one-clk50 pulse when the counters wrap to (0,0)
// BEHAVIOUR
//  - Reset (async): pixTick=0, hcount=0, vcount=0, all delay pipes cleared.
//    Output values during reset: hsync=1, vsync=1, red=green=blue=0, readEn=0, readAddress=0, vblank=0, frameStart=0.
//  - pixTick toggles every clk50 cycle (25 MHz pixel rate). Counters advance only in cycles where pixTick=1.
//  - hcount runs 0..799. At hcount=799 it wraps to 0 and vcount increments; vcount runs 0..524 and then wraps to 0.
//  - Horizontal timing: visible 0..639, front porch 640..655, sync 656..751 (hsync_raw=0), back porch 752..799.
//  - Vertical timing: visible 0..479, front porch 480..489, sync 490..491 (vsync_raw=0), back porch 492..524.
//  - Stage 0 (combinational from the counters): active = (hcount<640)&&(vcount<480).
//      lx = hcount>>SCALE_SHIFT, truncated to 8 bits.
//      ly = vcount>>SCALE_SHIFT, truncated to 9 bits.
//  - readEn and readAddress are registered from stage 0, so they are valid 1 clk50 cycle after a counter update.
//    They are held for both clk50 cycles of each pixel. Outside the active area, readEn=0 and readAddress holds its last value.
//  - active, hsync_raw and vsync_raw pass through a shift register of MEM_LATENCY+1 stages. Every stage advances on every clk50 cycle.
//  - red/green/blue are registered as readData & {3{active_d}}.
//  - hsync/vsync are the registered delayed raw syncs. The colour and sync outputs therefore stay mutually aligned.
//  - Total latency from a counter update to the corresponding pin change: MEM_LATENCY+2 clk50 cycles. This latency is constant.
//  - vblank is registered from (vcount>=480). It rises on the first tick of line 480 and falls on the tick into line 0.
//  - frameStart is high for exactly one clk50 cycle, registered, on the tick where (799,524)->(0,0).
//    It does NOT pulse on exit from reset.
//  - Reset asserted mid-frame: all outputs return to their reset values immediately.
//    After deassertion, scanning restarts at (0,0). No partial sync pulse may persist.
//  - Boundaries:
//      lx==159 at hcount 636..639 (SCALE_SHIFT=2). No read is issued for hcount>=640.
//      ly never exceeds 119 (SCALE_SHIFT=2).
// TESTING
//  1. Release reset, then count clk50 cycles between hsync falling edges. Required: 1600. hsync low width: 192 cycles.
//  2. Count clk50 cycles between vsync falling edges. Required: 840000. vsync low width: 3200 cycles.
//  3. Model memory returning readData = readAddress[2:0] with MEM_LATENCY=1 and 3.
//     Line 0: pins show colour 0 for 8 clk50 cycles, then colour 1, and so on.
//     Expected readAddress sequence: 0x00000, 0x00001, ...; pins go to 0 from hcount 640.
//  4. Check line 4 (SCALE_SHIFT=2). Required first address 0x00100 (ly=1, lx=0).
//     At vcount 480..524: readEn=0 throughout and vblank=1.
//  5. Check frameStart. Required: exactly 1 pulse per 840000 cycles and none immediately after reset.
//     Pulse coincides with vblank 1->0.
//  6. Assert reset at (hcount 700, vcount 491). Required: immediately hsync=1, vsync=1, rgb=0.
//     After release, the first hsync fall occurs 656*2+MEM_LATENCY+2 cycles later, adjusted to pixTick phase.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60Hz VGA scan-out of a 3-bpp framebuffer with 2^SCALE_SHIFT pixel replication
// Ports:
//     clk50, reset    50 MHz clock, asynchronous active-high reset
//     readEn          framebuffer read strobe, high only while the addressed pixel is visible
//     readAddress     {ly[8:0], lx[7:0]} logical pixel address, held outside the visible area
//     readData        {R,G,B} returned MEM_LATENCY clk50 cycles after the request
//     hsync, vsync    active-low syncs, delayed to stay aligned with the colour pins
//     red/green/blue  colour pins, forced low outside the visible area
//     vblank          high while vcount >= 480
//     frameStart      one-cycle pulse when the scan wraps to (0,0)
module vga_scanout #(
    parameter int SCALE_SHIFT = 2,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk50,
    input  logic        reset,
    output logic        readEn,
    output logic [16:0] readAddress,
    input  logic [2:0]  readData,
    output logic        hsync,
    output logic        vsync,
    output logic        red,
    output logic        green,
    output logic        blue,
    output logic        vblank,
    output logic        frameStart
);
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    logic                 pix_tick;
    logic [9:0]           hcount;
    logic [9:0]           vcount;
    logic                 h_end;
    logic                 v_end;
    logic                 active;
    logic                 hsync_raw;
    logic                 vsync_raw;
    logic [7:0]           lx;
    logic [8:0]           ly;
    logic [MEM_LATENCY:0] active_pipe;
    logic [MEM_LATENCY:0] hsync_pipe;
    logic [MEM_LATENCY:0] vsync_pipe;
    logic                 wrap;

    always_comb begin
        h_end     = hcount == H_LAST;
        v_end     = vcount == V_LAST;
        active    = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
        hsync_raw = !((hcount >= H_SYNC_START) && (hcount <= H_SYNC_END));
        vsync_raw = !((vcount >= V_SYNC_START) && (vcount <= V_SYNC_END));
        lx        = 8'(hcount >> SCALE_SHIFT);
        ly        = 9'(vcount >> SCALE_SHIFT);
    end

    // Counters only move on the 25 MHz phase, so each pixel spans two clk50 cycles.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            pix_tick <= 1'b0;
            hcount   <= '0;
            vcount   <= '0;
        end else begin
            pix_tick <= ~pix_tick;
            if (pix_tick) begin
                hcount <= h_end ? '0 : hcount + 10'd1;
                if (h_end)
                    vcount <= v_end ? '0 : vcount + 10'd1;
            end
        end
    end

    // Address holds outside the visible area so the memory sees no spurious changes.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            readEn      <= 1'b0;
            readAddress <= '0;
        end else begin
            readEn <= active;
            if (active)
                readAddress <= {ly, lx};
        end
    end

    // One stage covers the address register, MEM_LATENCY more cover the memory.
    // Sync stages clear to the inactive level so reset never leaves a sync pulse behind.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            active_pipe <= '0;
            hsync_pipe  <= '1;
            vsync_pipe  <= '1;
        end else begin
            active_pipe <= {active_pipe[MEM_LATENCY-1:0], active};
            hsync_pipe  <= {hsync_pipe[MEM_LATENCY-1:0], hsync_raw};
            vsync_pipe  <= {vsync_pipe[MEM_LATENCY-1:0], vsync_raw};
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= 3'b000;
            hsync              <= 1'b1;
            vsync              <= 1'b1;
        end else begin
            {red, green, blue} <= readData & {3{active_pipe[MEM_LATENCY]}};
            hsync              <= hsync_pipe[MEM_LATENCY];
            vsync              <= vsync_pipe[MEM_LATENCY];
        end
    end

    // wrap marks the counter wrap itself; delaying it one cycle lines frameStart up with the vblank fall.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            vblank     <= 1'b0;
            wrap       <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            vblank     <= vcount >= V_VISIBLE;
            wrap       <= pix_tick && h_end && v_end;
            frameStart <= wrap;
        end
    end
endmodule
